// File: rtl/mem_ld_arbiter_pkg.sv
// Shared types and constants for the load arbiter: tag type, error codes.
package mem_ld_arbiter_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_TAG_W   = $clog2(DEF_NUM_REQ);

  // Tag = index of the requester that owns an in-flight load
  typedef logic [DEF_TAG_W-1:0] tag_t;

  localparam logic [15:0] ERR_NONE        = 16'h0000;
  localparam logic [15:0] ERR_DATA_NO_TAG = 16'h0001;
  localparam logic [15:0] ERR_DONE_OVF    = 16'h0002;

endpackage

// File: rtl/mem_ld_arbiter_tag_fifo.sv
// In-order tag FIFO recording which requester owns each outstanding load.
module mem_ld_arbiter_tag_fifo
  import mem_ld_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = $bits(tag_t)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [TAG_W-1:0] i_push_tag,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [TAG_W-1:0] o_head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_MAX = DEPTH[PTR_W:0];

  logic [TAG_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_MAX);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_tag;
  end

  // Power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_ld_arbiter.sv
// Round-robin load arbiter: N requesters share one memory load port, data routed back by tag.
// Optional error reporting compiled in with MEM_LD_ARBITER_ERROR_EN.
module mem_ld_arbiter
  import mem_ld_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ         = DEF_NUM_REQ,
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic                          ldaddr_valid,
  input  logic                          ldaddr_ready,
  output logic [ADDR_WIDTH-1:0]         ldaddr_data,
  input  logic                          lddata_valid,
  output logic                          lddata_ready,
  input  logic [DATA_WIDTH-1:0]         lddata_data,
  input  logic                          lddone_valid,
  output logic                          lddone_ready,
  input  logic                          lddone_data,
  output logic [NUM_REQ-1:0]            resp_valid,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          error_valid,
  output logic [15:0]                   error_code
);

  localparam int unsigned TW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [TW-1:0] LAST_RST = TW'(NUM_REQ - 1);
  localparam logic [CW-1:0] DONE_MAX = CW'(MAX_OUTSTANDING);

  logic [TW-1:0]         r_last;
  logic                  r_lock;
  logic [TW-1:0]         r_lock_idx;
  logic [CW-1:0]         r_done;
  logic [TW-1:0]         w_rr_idx;
  logic [TW-1:0]         w_cand;
  logic [TW-1:0]         w_grant;
  logic [TW-1:0]         w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_addr_vld;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_done_inc;
  logic                  w_done_dec;
  logic [ADDR_WIDTH-1:0] w_addr [NUM_REQ];

  // Scan downward so the nearest valid requester after r_last wins
  always_comb begin
    w_rr_idx = TW'((int'(r_last) + 1) % NUM_REQ);
    w_cand   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = TW'((int'(r_last) + k) % NUM_REQ);
      if (req_valid[w_cand]) w_rr_idx = w_cand;
    end
  end

  assign w_grant    = r_lock ? r_lock_idx : w_rr_idx;
  assign w_addr_vld = req_valid[w_grant] && !w_full;
  assign w_push     = w_addr_vld && ldaddr_ready;
  assign w_pop      = lddata_valid && lddata_ready;

  assign ldaddr_valid = w_addr_vld;
  assign ldaddr_data  = w_addr[w_grant];

  assign lddata_ready = resp_ready[w_head] && !w_empty;
  assign resp_data    = lddata_data;
  assign lddone_ready = 1'b1;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign w_addr[g]     = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_ready[g]  = (w_grant == TW'(g)) && req_valid[g] && ldaddr_ready && !w_full;
    assign resp_valid[g] = (w_head == TW'(g)) && lddata_valid && !w_empty;
  end

  // Hold the grant across a back-pressured address so the winner cannot change mid-offer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= LAST_RST;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      r_lock     <= w_addr_vld && !ldaddr_ready;
      r_lock_idx <= w_grant;
      if (w_push) r_last <= w_grant;
    end
  end

  mem_ld_arbiter_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .TAG_W (TW)
  ) u_tag_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_tag (w_grant),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head     (w_head)
  );

  assign w_done_inc = lddone_valid && (r_done != DONE_MAX);
  assign w_done_dec = w_pop && (r_done != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= '0;
    end else begin
      case ({w_done_inc, w_done_dec})
        2'b10:   r_done <= r_done + 1'b1;
        2'b01:   r_done <= r_done - 1'b1;
        default: r_done <= r_done;
      endcase
    end
  end

`ifdef MEM_LD_ARBITER_ERROR_EN
  logic        r_err_vld;
  logic [15:0] r_err_code;
  logic        w_unused;

  // First error is sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_vld  <= 1'b0;
      r_err_code <= ERR_NONE;
    end else if (!r_err_vld) begin
      if (lddata_valid && w_empty) begin
        r_err_vld  <= 1'b1;
        r_err_code <= ERR_DATA_NO_TAG;
      end else if (lddone_valid && (r_done == DONE_MAX)) begin
        r_err_vld  <= 1'b1;
        r_err_code <= ERR_DONE_OVF;
      end
    end
  end

  assign error_valid = r_err_vld;
  assign error_code  = r_err_code;
  assign w_unused    = lddone_data;
`else
  logic w_unused;

  assign error_valid = 1'b0;
  assign error_code  = ERR_NONE;
  assign w_unused    = ^{lddone_data, r_done, ERR_DATA_NO_TAG, ERR_DONE_OVF};
`endif

endmodule
